// File: rtl/alu_issue_if.sv
// Issue-stage bus: instruction handshake in, ALU operands out, writeback in.
interface alu_issue_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic            out_valid;
   logic            out_ready;
   logic [3:0]      alu_opcode;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [4:0]      alu_rd;
   logic            wb_en;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            illegal;

   modport master (
      output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
      input  in_ready, out_valid, alu_opcode, alu_a, alu_b, alu_rd, illegal
   );

   modport slave (
      input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
      output in_ready, out_valid, alu_opcode, alu_a, alu_b, alu_rd, illegal
   );
endinterface

// File: rtl/alu_issue.sv
// Operand-fetch/issue stage: decode, register read with writeback bypass,
// pending-write scoreboard for RAW/WAW stalls, registered ALU operands.
module alu_issue #(
   parameter int XLEN  = 32,
   parameter int IMM_W = 12
) (
   input logic        clk,
   input logic        rst,
   alu_issue_if.slave bus
);

   localparam logic [3:0] OP_MAX = 4'b1000;

   typedef struct packed {
      logic [3:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        imm_sel;
      logic [11:0] imm;
   } instr_t;

   instr_t          d;
   logic [XLEN-1:0] regs [32];
   logic [31:0]     pending;
   logic [31:0]     set_mask;
   logic [31:0]     clr_mask;
   logic            legal;
   logic            hazard;
   logic            accept;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] imm_ext;

   // A pending index is harmless if its writeback lands this very cycle.
   function automatic logic busy(input logic [4:0] r, input logic [31:0] pend,
                                 input logic we, input logic [4:0] wr);
      return (r != 5'd0) && pend[r] && !(we && (wr == r));
   endfunction

   assign d       = instr_t'(bus.in_instr);
   assign legal   = (d.op <= OP_MAX);
   assign hazard  = legal && (busy(d.rs1, pending, bus.wb_en, bus.wb_rd) ||
                              (!d.imm_sel && busy(d.rs2, pending, bus.wb_en, bus.wb_rd)) ||
                              busy(d.rd, pending, bus.wb_en, bus.wb_rd));
   assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard;
   assign accept  = bus.in_valid && bus.in_ready;

   assign rs1_val = (d.rs1 == 5'd0) ? '0 :
                    (bus.wb_en && (bus.wb_rd == d.rs1)) ? bus.wb_data : regs[d.rs1];
   assign rs2_val = (d.rs2 == 5'd0) ? '0 :
                    (bus.wb_en && (bus.wb_rd == d.rs2)) ? bus.wb_data : regs[d.rs2];
   assign imm_ext = {{(XLEN-IMM_W){d.imm[IMM_W-1]}}, d.imm[IMM_W-1:0]};

   // NOTE: every signal driven from always_comb gets a default first, so no latch is inferred.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (accept && legal && (d.rd != 5'd0)) set_mask[d.rd] = 1'b1;
      if (bus.wb_en) clr_mask[bus.wb_rd] = 1'b1;
   end

   // NOTE: the register file is reset explicitly because R[*]=0 is architected state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
         regs[bus.wb_rd] <= bus.wb_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clr_mask) | set_mask;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid  <= 1'b0;
         bus.illegal    <= 1'b0;
         bus.alu_opcode <= '0;
         bus.alu_a      <= '0;
         bus.alu_b      <= '0;
         bus.alu_rd     <= '0;
      end else begin
         bus.illegal <= accept && !legal;
         if (accept && legal) begin
            bus.out_valid  <= 1'b1;
            bus.alu_opcode <= d.op;
            bus.alu_a      <= rs1_val;
            bus.alu_b      <= d.imm_sel ? imm_ext : rs2_val;
            bus.alu_rd     <= d.rd;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: stimulus pushes expected operands into a
// scoreboard queue; a monitor pops and compares on every output transfer.
module tb_alu_issue;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   alu_issue_if #(.XLEN(32)) vif ();

   alu_issue #(.XLEN(32), .IMM_W(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (vif)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic sel, input logic [11:0] imm);
      return {op, rd, rs1, rs2, sel, imm};
   endfunction

   function automatic exp_t mke(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd);
      exp_t e;
      e.op = op; e.a = a; e.b = b; e.rd = rd;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for one cycle; it must be accepted.
   task automatic send(input string name, input logic [31:0] ins, input exp_t e);
      vif.in_valid = 1'b1;
      vif.in_instr = ins;
      @(negedge clk);
      check({name, "_in_ready"}, 64'(vif.in_ready), 64'd1);
      if (vif.in_ready) sb.push_back(e);
      step();
      vif.in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && vif.out_valid && vif.out_ready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected_out: got rd=%0d with no op expected", vif.alu_rd);
         end else begin
            e = sb.pop_front();
            check("sb_opcode", 64'(vif.alu_opcode), 64'(e.op));
            check("sb_a",      64'(vif.alu_a),      64'(e.a));
            check("sb_b",      64'(vif.alu_b),      64'(e.b));
            check("sb_rd",     64'(vif.alu_rd),     64'(e.rd));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vif.in_valid  = 1'b0;
      vif.in_instr  = '0;
      vif.out_ready = 1'b1;
      vif.wb_en     = 1'b0;
      vif.wb_rd     = '0;
      vif.wb_data   = '0;
      step();
      step();
      @(negedge clk);
      check("rst_out_valid", 64'(vif.out_valid),  64'd0);
      check("rst_illegal",   64'(vif.illegal),    64'd0);
      check("rst_opcode",    64'(vif.alu_opcode), 64'd0);
      check("rst_a",         64'(vif.alu_a),      64'd0);
      check("rst_b",         64'(vif.alu_b),      64'd0);
      check("rst_rd",        64'(vif.alu_rd),     64'd0);
      step();
      rst = 1'b0;

      // Writeback R1=5, then ADDI r2 = r1 + (-1)
      vif.wb_en = 1'b1; vif.wb_rd = 5'd1; vif.wb_data = 32'd5;
      step();
      vif.wb_en = 1'b0;
      send("addi", mk(4'd0, 5'd2, 5'd1, 5'd0, 1'b1, 12'hFFF), mke(4'd0, 32'd5, 32'hFFFF_FFFF, 5'd2));
      @(negedge clk);
      check("addi_out_valid", 64'(vif.out_valid), 64'd1);
      step();

      // RAW stall on r3, released by a same-cycle writeback with bypass
      send("wr_r3", mk(4'd0, 5'd3, 5'd1, 5'd1, 1'b0, 12'd0), mke(4'd0, 32'd5, 32'd5, 5'd3));
      vif.in_valid = 1'b1;
      vif.in_instr = mk(4'd0, 5'd5, 5'd3, 5'd0, 1'b1, 12'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("raw_stall", 64'(vif.in_ready), 64'd0);
         step();
      end
      vif.wb_en = 1'b1; vif.wb_rd = 5'd3; vif.wb_data = 32'd9;
      send("bypass", mk(4'd0, 5'd5, 5'd3, 5'd0, 1'b1, 12'd1), mke(4'd0, 32'd9, 32'd1, 5'd5));
      vif.wb_en = 1'b0;
      send("r3_clear", mk(4'd1, 5'd6, 5'd3, 5'd3, 1'b0, 12'd0), mke(4'd1, 32'd9, 32'd9, 5'd6));

      // Backpressure: outputs hold, in_ready low
      vif.out_ready = 1'b0;
      vif.in_valid  = 1'b1;
      vif.in_instr  = mk(4'd2, 5'd7, 5'd1, 5'd0, 1'b1, 12'd3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready",  64'(vif.in_ready),   64'd0);
         check("bp_out_valid", 64'(vif.out_valid),  64'd1);
         check("bp_opcode",    64'(vif.alu_opcode), 64'd1);
         check("bp_a",         64'(vif.alu_a),      64'd9);
         check("bp_rd",        64'(vif.alu_rd),     64'd6);
         step();
      end
      vif.out_ready = 1'b1;
      send("b2b0", mk(4'd2, 5'd7,  5'd1, 5'd0, 1'b1, 12'd3),    mke(4'd2, 32'd5, 32'd3,         5'd7));
      send("b2b1", mk(4'd3, 5'd8,  5'd1, 5'd0, 1'b1, 12'h800),  mke(4'd3, 32'd5, 32'hFFFF_F800, 5'd8));
      send("b2b2", mk(4'd4, 5'd9,  5'd0, 5'd1, 1'b0, 12'd0),    mke(4'd4, 32'd0, 32'd5,         5'd9));
      send("b2b3", mk(4'd8, 5'd10, 5'd1, 5'd0, 1'b1, 12'h7FF),  mke(4'd8, 32'd5, 32'h0000_07FF, 5'd10));
      @(negedge clk);
      check("b2b_last_valid", 64'(vif.out_valid), 64'd1);
      step();
      @(negedge clk);
      check("drain_out_valid", 64'(vif.out_valid), 64'd0);
      step();

      // Illegal op: consumed despite pending rs1=5, 1-cycle pulse, nothing issued
      vif.in_valid = 1'b1;
      vif.in_instr = mk(4'hA, 5'd11, 5'd5, 5'd0, 1'b0, 12'd0);
      @(negedge clk);
      check("ill_in_ready", 64'(vif.in_ready), 64'd1);
      check("ill_pre",      64'(vif.illegal),  64'd0);
      step();
      vif.in_valid = 1'b0;
      @(negedge clk);
      check("ill_pulse",     64'(vif.illegal),   64'd1);
      check("ill_out_valid", 64'(vif.out_valid), 64'd0);
      step();
      @(negedge clk);
      check("ill_post", 64'(vif.illegal), 64'd0);
      step();
      send("ill_rd_free", mk(4'd0, 5'd12, 5'd11, 5'd0, 1'b1, 12'd0), mke(4'd0, 32'd0, 32'd0, 5'd12));
      vif.in_valid = 1'b1;
      vif.in_instr = mk(4'd0, 5'd13, 5'd5, 5'd0, 1'b1, 12'd0);
      @(negedge clk);
      check("r5_still_pending", 64'(vif.in_ready), 64'd0);
      step();
      vif.wb_en = 1'b1; vif.wb_rd = 5'd5; vif.wb_data = 32'h55;
      send("r5_wb", mk(4'd0, 5'd13, 5'd5, 5'd0, 1'b1, 12'd0), mke(4'd0, 32'h55, 32'd0, 5'd13));
      vif.wb_en = 1'b0;

      // rd=0: never pending, writes ignored
      send("rd0", mk(4'd0, 5'd0, 5'd1, 5'd0, 1'b1, 12'd2), mke(4'd0, 32'd5, 32'd2, 5'd0));
      vif.wb_en = 1'b1; vif.wb_rd = 5'd0; vif.wb_data = 32'd7;
      step();
      vif.wb_en = 1'b0;
      send("r0_read", mk(4'd0, 5'd14, 5'd0, 5'd0, 1'b0, 12'd0), mke(4'd0, 32'd0, 32'd0, 5'd14));

      // Async reset with out_valid=1 and pending[4]=1
      vif.wb_en = 1'b1; vif.wb_rd = 5'd4; vif.wb_data = 32'h44;
      step();
      vif.wb_en = 1'b0;
      vif.out_ready = 1'b0;
      send("wr_r4", mk(4'd0, 5'd4, 5'd1, 5'd0, 1'b1, 12'd0), mke(4'd0, 32'd5, 32'd0, 5'd4));
      @(negedge clk);
      check("pre_rst_valid", 64'(vif.out_valid), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", 64'(vif.out_valid), 64'd0);
      check("arst_rd",        64'(vif.alu_rd),    64'd0);
      check("arst_a",         64'(vif.alu_a),     64'd0);
      sb.delete();
      step();
      step();
      rst = 1'b0;
      vif.out_ready = 1'b1;
      send("post_rst", mk(4'd0, 5'd15, 5'd4, 5'd1, 1'b0, 12'd0), mke(4'd0, 32'd0, 32'd0, 5'd15));
      step();
      step();
      @(negedge clk);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
